// File: rtl/ex_mem_elastic_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_elastic_stage
// Purpose  : EX->MEM pipeline stage built as a 2-entry valid/ready skid
//            buffer. A MEM-side stall never creates a combinational ready
//            path back into EX. Supports synchronous flush (squash) and
//            forces all control bits low on bubbles.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            i_flush             - squash buffered entries and current input
//            i_in_valid/o_in_ready, i_in_ctrl/i_in_alures/i_in_stdata/i_in_dest
//                                - EX-side handshake and payload
//            o_out_valid/i_out_ready, o_out_ctrl/o_out_alures/o_out_stdata/o_out_dest
//                                - MEM-side handshake and payload
//            o_occ               - occupancy 0..2
//            ctrl = {vf, wreg, wmem, rmem}
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_elastic_stage #(
  parameter int DATA_W = 128,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [3:0]        i_in_ctrl,
  input  logic [DATA_W-1:0] i_in_alures,
  input  logic [DATA_W-1:0] i_in_stdata,
  input  logic [DEST_W-1:0] i_in_dest,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [3:0]        o_out_ctrl,
  output logic [DATA_W-1:0] o_out_alures,
  output logic [DATA_W-1:0] o_out_stdata,
  output logic [DEST_W-1:0] o_out_dest,
  output logic [1:0]        o_occ
);

  localparam int c_ENTRY_W = 4 + 2*DATA_W + DEST_W;

  // State encoding equals occupancy so o_occ is a direct register read.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [c_ENTRY_W-1:0]   r_main;
  logic [c_ENTRY_W-1:0]   r_skid;
  logic [c_ENTRY_W-1:0]   w_in_entry;
  logic                   w_in_xfer;
  logic                   w_out_xfer;
  logic                   w_load_main_in;
  logic                   w_load_main_skid;
  logic                   w_load_skid;

  assign w_in_entry = {i_in_ctrl, i_in_alures, i_in_stdata, i_in_dest};
  assign w_in_xfer  = i_in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & i_out_ready;

  // State register; handshake flags are registered copies of the next state
  // so neither in_ready nor out_valid depends combinationally on inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (i_flush) begin
      // Anything not handed to MEM this cycle, plus the input, is squashed.
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            w_load_main_in = 1'b1;
            w_state_nxt    = S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_main_in = 1'b1;
          end else if (w_in_xfer) begin
            w_load_skid = 1'b1;
            w_state_nxt = S_FULL;
          end else if (w_out_xfer) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only the output side can move.
          if (w_out_xfer) begin
            w_load_main_skid = 1'b1;
            w_state_nxt      = S_ONE;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // Payload storage. Main holds its last value when empty (don't-care).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= w_in_entry;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (i_flush) begin
        r_skid <= '0;
      end else if (w_load_skid) begin
        r_skid <= w_in_entry;
      end
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_out_valid  = r_out_valid;
  // Gate control bits so rmem/wmem/wreg/vf never assert on a bubble.
  assign o_out_ctrl   = r_out_valid ? r_main[c_ENTRY_W-1 -: 4] : 4'h0;
  assign o_out_alures = r_main[2*DATA_W+DEST_W-1 -: DATA_W];
  assign o_out_stdata = r_main[DATA_W+DEST_W-1 -: DATA_W];
  assign o_out_dest   = r_main[DEST_W-1:0];
  assign o_occ        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_elastic_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_elastic_stage
// Purpose  : Scoreboard bench for ex_mem_elastic_stage. Two instances
//            (128/4 and 64/5) share stimulus; a capacity-2 FIFO model
//            predicts occupancy, handshakes and output order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_elastic_stage;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [3:0]   in_ctrl;
  logic [127:0] in_alu;
  logic [127:0] in_st;
  logic [4:0]   in_dest;

  logic         d1_in_ready, d1_out_valid;
  logic [3:0]   d1_ctrl;
  logic [127:0] d1_alu, d1_st;
  logic [3:0]   d1_dest;
  logic [1:0]   d1_occ;

  logic         d2_in_ready, d2_out_valid;
  logic [3:0]   d2_ctrl;
  logic [63:0]  d2_alu, d2_st;
  logic [4:0]   d2_dest;
  logic [1:0]   d2_occ;

  ex_mem_elastic_stage #(.DATA_W(128), .DEST_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(d1_in_ready),
    .i_in_ctrl(in_ctrl), .i_in_alures(in_alu), .i_in_stdata(in_st),
    .i_in_dest(in_dest[3:0]),
    .o_out_valid(d1_out_valid), .i_out_ready(out_ready),
    .o_out_ctrl(d1_ctrl), .o_out_alures(d1_alu), .o_out_stdata(d1_st),
    .o_out_dest(d1_dest), .o_occ(d1_occ)
  );

  ex_mem_elastic_stage #(.DATA_W(64), .DEST_W(5)) u_dut2 (
    .clk(clk), .rst(rst), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(d2_in_ready),
    .i_in_ctrl(in_ctrl), .i_in_alures(in_alu[63:0]), .i_in_stdata(in_st[63:0]),
    .i_in_dest(in_dest),
    .o_out_valid(d2_out_valid), .i_out_ready(out_ready),
    .o_out_ctrl(d2_ctrl), .o_out_alures(d2_alu), .o_out_stdata(d2_st),
    .o_out_dest(d2_dest), .o_occ(d2_occ)
  );

  typedef struct packed {
    logic [3:0]   ctrl;
    logic [127:0] alu;
    logic [127:0] st;
    logic [4:0]   dest;
  } item_t;

  item_t sb[$];       // expected output order
  int    m_cnt = 0;   // model occupancy
  int    vectors = 0;
  int    miscompares = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic item_t mk(input logic [3:0] c, input logic [127:0] a, input logic [4:0] d);
    item_t it;
    it.ctrl = c;
    it.alu  = a;
    it.st   = ~a;
    it.dest = d;
    return it;
  endfunction

  function automatic item_t rnd_item();
    item_t it;
    it.ctrl = 4'($urandom);
    it.alu  = {$urandom, $urandom, $urandom, $urandom};
    it.st   = {$urandom, $urandom, $urandom, $urandom};
    it.dest = 5'($urandom);
    return it;
  endfunction

  // Monitor: checks handshakes against the model and pops the scoreboard
  // whenever the model says the MEM side is taking an entry this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      item_t e;
      chk("occ1",       128'(d1_occ),       128'(m_cnt));
      chk("occ2",       128'(d2_occ),       128'(m_cnt));
      chk("in_ready1",  128'(d1_in_ready),  128'(m_cnt < 2));
      chk("in_ready2",  128'(d2_in_ready),  128'(m_cnt < 2));
      chk("out_valid1", 128'(d1_out_valid), 128'(m_cnt > 0));
      chk("out_valid2", 128'(d2_out_valid), 128'(m_cnt > 0));
      if (m_cnt == 0) begin
        chk("bubble_ctrl1", 128'(d1_ctrl), 128'(0));
        chk("bubble_ctrl2", 128'(d2_ctrl), 128'(0));
      end
      if (m_cnt > 0 && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 128'(0), 128'(1));
        end else begin
          e = sb.pop_front();
          chk("ctrl1",  128'(d1_ctrl), 128'(e.ctrl));
          chk("alu1",   d1_alu,        e.alu);
          chk("st1",    d1_st,         e.st);
          chk("dest1",  128'(d1_dest), 128'(e.dest[3:0]));
          chk("ctrl2",  128'(d2_ctrl), 128'(e.ctrl));
          chk("alu2",   128'(d2_alu),  128'(e.alu[63:0]));
          chk("st2",    128'(d2_st),   128'(e.st[63:0]));
          chk("dest2",  128'(d2_dest), 128'(e.dest));
        end
      end
    end
  end

  // One clock of stimulus, followed by the model update for that edge.
  task automatic step(input bit v, input bit f, input bit o, input bit r,
                      input item_t it, output bit acc);
    bit out_x, in_x;
    int rem;
    rst       = r;
    flush     = f;
    in_valid  = v;
    out_ready = o;
    in_ctrl   = it.ctrl;
    in_alu    = it.alu;
    in_st     = it.st;
    in_dest   = it.dest;
    @(posedge clk);
    out_x = (m_cnt > 0) && o;
    in_x  = v && (m_cnt < 2) && !f && !r;
    if (r) begin
      sb.delete();
      m_cnt = 0;
    end else if (f) begin
      rem = m_cnt - int'(out_x);
      repeat (rem) if (sb.size() > 0) void'(sb.pop_back());
      m_cnt = 0;
    end else begin
      m_cnt = m_cnt - int'(out_x) + int'(in_x);
      if (in_x) sb.push_back(it);
    end
    acc = in_x;
    #1;
  endtask

  task automatic idle(input bit o, input int n);
    bit acc;
    repeat (n) step(1'b0, 1'b0, o, 1'b0, rnd_item(), acc);
  endtask

  task automatic push_hold(input item_t it, input bit o);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      step(1'b1, 1'b0, o, 1'b0, it, acc);
      n++;
    end
    chk("push_timeout", 128'(acc), 128'(1));
  endtask

  initial begin
    bit acc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_ctrl = 4'hF; in_alu = '1; in_st = '1; in_dest = '1;

    // Reset for two cycles with in_valid high.
    step(1'b1, 1'b0, 1'b0, 1'b1, rnd_item(), acc);
    mon_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1, rnd_item(), acc);
    chk("rst_alu1",  d1_alu,         128'(0));
    chk("rst_st1",   d1_st,          128'(0));
    chk("rst_dest1", 128'(d1_dest),  128'(0));
    chk("rst_alu2",  128'(d2_alu),   128'(0));
    chk("rst_st2",   128'(d2_st),    128'(0));
    chk("rst_dest2", 128'(d2_dest),  128'(0));

    // Streaming 1..8 with out_ready high.
    for (int i = 1; i <= 8; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, mk(4'(i), 128'(i), 5'(i)), acc);
    idle(1'b1, 3);

    // Stall fill: A, B accepted, C held until space frees.
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(4'b0101, 128'hA, 5'd10), acc);
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(4'b0010, 128'hB, 5'd11), acc);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, mk(4'b0100, 128'hC, 5'd12), acc);
    push_hold(mk(4'b0100, 128'hC, 5'd12), 1'b1);
    idle(1'b1, 4);

    // Flush while full, with a valid input that must be discarded.
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(4'b0011, 128'h11, 5'd1), acc);
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(4'b0110, 128'h22, 5'd2), acc);
    step(1'b1, 1'b1, 1'b0, 1'b0, mk(4'b1111, 128'hBAD, 5'd31), acc);
    idle(1'b1, 3);

    // Flush coinciding with an output transfer of D.
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(4'b1001, 128'hD, 5'd13), acc);
    step(1'b0, 1'b1, 1'b1, 1'b0, rnd_item(), acc);
    idle(1'b1, 2);

    // Bubble gating after an all-ones control entry drains.
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(4'b1111, 128'hFF, 5'd15), acc);
    idle(1'b1, 3);
    idle(1'b0, 2);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 3) != 0,
           ($urandom % 300) == 0, rnd_item(), acc);
    end
    idle(1'b1, 4);
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mem_elastic_stage.md
# ex_mem_elastic_stage

Parametrised, back-pressure-aware successor to the fixed EX/MEM pipeline latch of the vector ASIP. It carries the EX results (ALU result, store operand, destination register, control bits, vector flag) into the MEM stage through a 2-entry valid/ready skid buffer, so that a MEM-side stall does not need a combinational ready path back into EX. It supports synchronous flush for branch/exception squash and inserts bubbles with all control bits forced low. It sits between the EX ALU/vector unit and the data-memory stage.

## Interface
- DATA_W, 128, width of ALU result and store operand
- DEST_W, 4, width of destination register index
- ctrl bits are fixed: rmem, wmem, wreg, vf (packed as ctrl[3:0] = {vf, wreg, wmem, rmem})
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash all buffered entries and the current input
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_ctrl  in  4  {vf, wreg, wmem, rmem}
- in_alures  in  DATA_W  ALU/vector result
- in_stdata  in  DATA_W  store operand (R3/V3)
- in_dest  in  DEST_W  destination register index
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM stage accepts
- out_ctrl  out  4  control bits; forced 4'h0 whenever out_valid=0
- out_alures, out_stdata  out  DATA_W  entry payload
- out_dest  out  DEST_W  entry destination
- occ  out  2  occupancy, 0..2

## Operation
- Two entries: main (drives outputs) and skid. All storage registered; no combinational in-to-out path.
- Input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- States by occupancy:
  - EMPTY (occ=0): input transfer -> load main, go ONE.
  - ONE (occ=1): in xfer & out xfer -> main replaced by input, stay ONE; in xfer & no out xfer -> load skid, go FULL; no in xfer & out xfer -> EMPTY; neither -> hold.
  - FULL (occ=2): in_ready=0; out xfer -> main<=skid, go ONE; else hold.
- Ordering strictly FIFO; no entry is ever dropped or duplicated except by flush/rst.
- Flush (priority below rst): next state EMPTY, skid cleared, input in same cycle discarded. An output transfer completing in the flush cycle is valid (MEM has consumed it); entries not yet transferred are lost.
- Bubble: out_valid=0 -> out_ctrl=0 so rmem/wmem/wreg/vf never spuriously assert downstream; payload outputs hold last value (don't-care).
- Widths pass through unchanged; no arithmetic on payload.

## Timing
- rst: occ=0, out_valid=0, in_ready=1, out_ctrl=0, out_alures=0, out_stdata=0, out_dest=0, skid contents 0. Applies on the next rising edge; mid-operation reset discards everything.
- Latency: input accepted at edge N -> out_valid=1 with that payload after edge N (visible cycle N+1).
- Throughput: 1 entry/cycle when out_ready held high.
- in_ready drops the cycle after the skid fills; rises the cycle after FULL drains to ONE.
- Flush at edge N: after edge N out_valid=0, in_ready=1, occ=0.
- rst and flush together: reset behaviour.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 -> outputs all zero, occ=0, in_ready=1; first input after release appears one cycle later.
- Streaming: out_ready=1, push alures=0x1..0x8, dest=1..8 back-to-back -> same sequence at output, one per cycle, 1-cycle latency, in_ready never low.
- Stall fill: push A (ctrl=4'b0101), B, C with out_ready=0 -> occ=1 then 2, in_ready=0 after B, C held at input; release out_ready -> A, B, C out in order, no loss.
- Flush when FULL: occ=2, assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occ=0; flushed input never appears.
- Flush with concurrent out transfer: occ=1 entry D, out_ready=1, flush=1 -> D counted transferred that cycle, next cycle empty.
- Bubble gating: after drain with last ctrl=4'b1111 -> out_ctrl=0 while out_valid=0; parameter run DATA_W=64, DEST_W=5 passes streaming test.
